// File: rtl/exu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// exu_issue_ctrl
// Execute-stage sequencer sitting directly in front of the fused ALU.
//
// Takes one decoded op from ID over a valid/ready handshake and latches its
// operands, opcode, rd and wen. The latched copy drives the ALU inputs for as
// long as the op is in flight. Single-cycle ops are captured from alu_out on the
// cycle after accept. Multi-cycle ops (div/rem, and mul when MUL_MULTICYCLE=1)
// get a one-cycle alu_en start strobe, then the block waits for alu_valid. The
// 64-bit result, rd and wen are registered and offered to MEM/WB over a second
// valid/ready handshake.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 drop the op held here (redirect)
//   id_valid/id_ready     ID -> EX handshake
//   id_in0/id_in1         operands
//   id_alu_op             ALU opcode (bit6 = word op)
//   id_rd/id_wen          destination register and its write enable
//   alu_in0/alu_in1/alu_op  held operands/opcode driven to the ALU
//   alu_en                start strobe for multi-cycle ops
//   alu_ready/alu_valid   ALU can start / ALU result valid
//   alu_out               ALU result
//   ex_valid/ex_ready     EX -> MEM/WB handshake
//   ex_result/ex_rd/ex_wen  registered result, rd and wen
// -----------------------------------------------------------------------------
module exu_issue_ctrl #(
  parameter int MUL_MULTICYCLE = 0,
  parameter int DATA_W         = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [DATA_W-1:0] id_in0,
  input  logic [DATA_W-1:0] id_in1,
  input  logic [6:0]        id_alu_op,
  input  logic [4:0]        id_rd,
  input  logic              id_wen,
  output logic [DATA_W-1:0] alu_in0,
  output logic [DATA_W-1:0] alu_in1,
  output logic [6:0]        alu_op,
  output logic              alu_en,
  input  logic              alu_valid,
  input  logic              alu_ready,
  input  logic [DATA_W-1:0] alu_out,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [DATA_W-1:0] ex_result,
  output logic [4:0]        ex_rd,
  output logic              ex_wen
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    EXEC  = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    DRAIN = 3'd4
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   op_in0;
  logic [DATA_W-1:0]   op_in1;
  logic [6:0]          op_alu;
  logic [4:0]          op_rd;
  logic                op_wen;
  logic                op_mc;
  logic                accept;

  // Divide/remainder class always goes through the iterative unit; the
  // multiply class does so only when the multiplier is built multi-cycle.
  function automatic logic is_mc(input logic [6:0] op);
    return (op[4:2] == 3'b111) ||
           ((MUL_MULTICYCLE != 0) && (op[4:2] == 3'b110));
  endfunction

  assign op_mc    = is_mc(op_alu);
  assign id_ready = ~flush & ((state == IDLE) | ((state == DONE) & ex_ready));
  assign accept   = id_valid & id_ready;

  // Start strobe follows alu_ready while the op waits to issue. It is not
  // gated by flush: a start that fires alongside a flush still launches the
  // divider, which is why that case goes to DRAIN.
  assign alu_en   = (state == EXEC) & op_mc & alu_ready;
  assign ex_valid = (state == DONE);

  assign alu_in0  = op_in0;
  assign alu_in1  = op_in1;
  assign alu_op   = op_alu;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_in0    <= '0;
      op_in1    <= '0;
      op_alu    <= '0;
      op_rd     <= '0;
      op_wen    <= 1'b0;
      ex_result <= '0;
      ex_rd     <= '0;
      ex_wen    <= 1'b0;
    end else begin
      if (accept) begin
        op_in0 <= id_in0;
        op_in1 <= id_in1;
        op_alu <= id_alu_op;
        op_rd  <= id_rd;
        op_wen <= id_wen;
      end

      if (flush) begin
        // A divider already running cannot be cancelled, so its eventual
        // alu_valid must be swallowed in DRAIN unless it arrives right now.
        case (state)
          EXEC:    state <= alu_en ? DRAIN : IDLE;
          WAIT:    state <= alu_valid ? IDLE : DRAIN;
          DRAIN:   state <= DRAIN;
          default: state <= IDLE;
        endcase
      end else begin
        case (state)
          IDLE: begin
            if (accept) state <= EXEC;
          end
          EXEC: begin
            if (!op_mc) begin
              ex_result <= alu_out;
              ex_rd     <= op_rd;
              ex_wen    <= op_wen;
              state     <= DONE;
            end else if (alu_ready) begin
              state <= WAIT;
            end
          end
          WAIT: begin
            if (alu_valid) begin
              ex_result <= alu_out;
              ex_rd     <= op_rd;
              ex_wen    <= op_wen;
              state     <= DONE;
            end
          end
          DONE: begin
            // With flush low, accept here is exactly ex_ready & id_valid.
            if (ex_ready) state <= id_valid ? EXEC : IDLE;
          end
          DRAIN: begin
            if (alu_valid) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exu_issue_ctrl.sv
module tb_exu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        id_valid = 1'b0;
  logic        id_ready;
  logic [63:0] id_in0 = '0;
  logic [63:0] id_in1 = '0;
  logic [6:0]  id_alu_op = '0;
  logic [4:0]  id_rd = '0;
  logic        id_wen = 1'b0;
  logic [63:0] alu_in0, alu_in1, alu_out;
  logic [6:0]  alu_op;
  logic        alu_en;
  logic        alu_valid;
  logic        alu_ready = 1'b1;
  logic        ex_valid;
  logic        ex_ready = 1'b1;
  logic [63:0] ex_result;
  logic [4:0]  ex_rd;
  logic        ex_wen;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [6:0] OP_ADD  = 7'b0000000;
  localparam logic [6:0] OP_DIVU = 7'b0011101;
  localparam logic [6:0] OP_REMU = 7'b0011111;

  exu_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_in0(id_in0), .id_in1(id_in1), .id_alu_op(id_alu_op),
    .id_rd(id_rd), .id_wen(id_wen),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_op(alu_op), .alu_en(alu_en),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_out(alu_out),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_result(ex_result), .ex_rd(ex_rd), .ex_wen(ex_wen)
  );

  always #5 clk = ~clk;

  // ---------------- ALU environment ----------------
  function automatic logic [63:0] alu_func(input logic [6:0] op,
                                           input logic [63:0] a,
                                           input logic [63:0] b);
    case (op)
      OP_DIVU: return (b == 0) ? '1 : a / b;
      OP_REMU: return (b == 0) ? a : a % b;
      default: return a + b;
    endcase
  endfunction

  function automatic logic is_div(input logic [6:0] op);
    return op[4:2] == 3'b111;
  endfunction

  assign alu_out = alu_func(alu_op, alu_in0, alu_in1);

  // Divider answers 10 cycles after its start strobe; not cancellable by flush.
  int div_cnt = 0;
  always @(posedge clk) begin
    if (!rst_n)           div_cnt <= 0;
    else if (alu_en)      div_cnt <= 10;
    else if (div_cnt != 0) div_cnt <= div_cnt - 1;
  end
  assign alu_valid = (div_cnt == 1);

  int en_cnt = 0;
  always @(posedge clk) if (alu_en === 1'b1) en_cnt <= en_cnt + 1;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an op is either pending (held, maybe with the divider
  // launched), a result is on offer, or a flushed divide is being drained.
  logic        m_pend = 0, m_started = 0, m_res_v = 0, m_drain = 0;
  logic [63:0] m_in0 = 0, m_in1 = 0, m_res = 0;
  logic [6:0]  m_op = 0;
  logic [4:0]  m_rd = 0, m_xrd = 0;
  logic        m_wen = 0, m_xwen = 0;

  function automatic logic exp_ready();
    return !flush && ((!m_pend && !m_res_v && !m_drain) || (m_res_v && ex_ready));
  endfunction

  function automatic logic exp_en();
    return m_pend && !m_started && is_div(m_op) && alu_ready;
  endfunction

  task automatic m_capture();
    m_res = alu_func(m_op, m_in0, m_in1);
    m_xrd = m_rd; m_xwen = m_wen;
    m_res_v = 1; m_pend = 0; m_started = 0;
  endtask

  always @(posedge clk) begin
    logic en_now, rdy_now;
    en_now  = exp_en();
    rdy_now = exp_ready();
    if (!rst_n) begin
      m_pend = 0; m_started = 0; m_res_v = 0; m_drain = 0;
      m_in0 = 0; m_in1 = 0; m_op = 0; m_rd = 0; m_wen = 0;
      m_res = 0; m_xrd = 0; m_xwen = 0;
    end else if (flush) begin
      if (m_pend && m_started) m_drain = !alu_valid;
      else if (en_now)         m_drain = 1;
      m_pend = 0; m_started = 0; m_res_v = 0;
    end else begin
      if (m_drain && alu_valid) m_drain = 0;
      if (m_res_v && ex_ready)  m_res_v = 0;
      if (m_pend) begin
        if (!is_div(m_op))    m_capture();
        else if (!m_started)  m_started = alu_ready;
        else if (alu_valid)   m_capture();
      end
      if (rdy_now && id_valid) begin
        m_in0 = id_in0; m_in1 = id_in1; m_op = id_alu_op;
        m_rd = id_rd; m_wen = id_wen;
        m_pend = 1; m_started = 0;
      end
    end
  end

  logic chk_en = 0;
  logic prev_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      chk("id_ready",  id_ready,  exp_ready());
      chk("ex_valid",  ex_valid,  m_res_v);
      chk("alu_en",    alu_en,    exp_en());
      chk("alu_in0",   alu_in0,   m_in0);
      chk("alu_in1",   alu_in1,   m_in1);
      chk("alu_op",    alu_op,    m_op);
      chk("ex_result", ex_result, m_res);
      chk("ex_rd",     ex_rd,     m_xrd);
      chk("ex_wen",    ex_wen,    m_xwen);
      if (prev_en) chk("alu_en_twice", alu_en, 0);
      prev_en = alu_en;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic [6:0] op, input logic [4:0] rd);
    logic found;
    found = 0;
    id_in0 = a; id_in1 = b; id_alu_op = op; id_rd = rd; id_wen = 1'b1;
    id_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (id_ready) begin found = 1; break; end
      tick();
    end
    if (!found) chk("accept_timeout", found, 1);
    tick();
    id_valid = 1'b0;
  endtask

  // Returns at the falling edge of the first cycle with ex_valid high.
  task automatic wait_ex();
    logic found;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ex_valid) begin found = 1; break; end
      tick();
    end
    if (!found) chk("ex_valid_timeout", found, 1);
  endtask

  // In DRAIN until the discarded divider answer arrives, then IDLE.
  task automatic drain_check();
    logic found;
    found = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("drain_id_ready", id_ready, 0);
      chk("drain_ex_valid", ex_valid, 0);
      if (alu_valid) begin found = 1; break; end
      tick();
    end
    if (!found) chk("drain_timeout", found, 1);
    tick();
    @(negedge clk);
    chk("post_drain_id_ready", id_ready, 1);
    tick();
  endtask

  int en0;

  initial begin
    tick(); tick();
    rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_id_ready", id_ready, 1);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_result", ex_result, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_alu_en", alu_en, 0);
    tick();

    // ADD 5+7: result two cycles after accept, no start strobe
    en0 = en_cnt;
    send(64'd5, 64'd7, OP_ADD, 5'd3);
    @(negedge clk);
    chk("add_cyc1_ex_valid", ex_valid, 0);
    tick();
    @(negedge clk);
    chk("add_ex_valid", ex_valid, 1);
    chk("add_result", ex_result, 64'd12);
    chk("add_rd", ex_rd, 5'd3);
    chk("add_no_en", en_cnt - en0, 0);
    tick();

    // DIVU 100/7 and REMU 100%7
    en0 = en_cnt;
    send(64'd100, 64'd7, OP_DIVU, 5'd5);
    tick(); tick();
    @(negedge clk);
    chk("divu_hold_in1", alu_in1, 64'd7);
    chk("divu_hold_op", alu_op, OP_DIVU);
    wait_ex();
    chk("divu_result", ex_result, 64'd14);
    chk("divu_one_pulse", en_cnt - en0, 1);
    tick();
    en0 = en_cnt;
    send(64'd100, 64'd7, OP_REMU, 5'd6);
    wait_ex();
    chk("remu_result", ex_result, 64'd2);
    chk("remu_one_pulse", en_cnt - en0, 1);
    tick();

    // Backpressure in DONE with a queued op behind it
    ex_ready = 1'b0;
    send(64'd5, 64'd7, OP_ADD, 5'd9);
    wait_ex();
    tick();
    id_in0 = 64'd1; id_in1 = 64'd2; id_alu_op = OP_ADD; id_rd = 5'd4; id_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", ex_result, 64'd12);
      chk("bp_rd", ex_rd, 5'd9);
      chk("bp_id_ready", id_ready, 0);
      tick();
    end
    ex_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_id_ready", id_ready, 1);
    tick();
    id_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("bp_next_valid", ex_valid, 1);
    chk("bp_next_result", ex_result, 64'd3);
    chk("bp_next_rd", ex_rd, 5'd4);
    tick();

    // Issue stall: alu_ready low for 3 cycles in EXEC
    alu_ready = 1'b0;
    en0 = en_cnt;
    send(64'd100, 64'd7, OP_DIVU, 5'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_alu_en", alu_en, 0);
      tick();
    end
    alu_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_en", alu_en, 1);
    tick();
    @(negedge clk);
    chk("stall_after_en", alu_en, 0);
    wait_ex();
    chk("stall_result", ex_result, 64'd14);
    chk("stall_one_pulse", en_cnt - en0, 1);
    tick();

    // Flush mid-divide
    send(64'd100, 64'd7, OP_DIVU, 5'd8);
    tick(); tick(); tick();
    flush = 1'b1;
    @(negedge clk);
    chk("flush_wait_id_ready", id_ready, 0);
    tick();
    flush = 1'b0;
    drain_check();

    // Flush on the cycle the start strobe fires
    send(64'd50, 64'd3, OP_DIVU, 5'd9);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_exec_en", alu_en, 1);
    chk("flush_exec_id_ready", id_ready, 0);
    tick();
    flush = 1'b0;
    drain_check();

    // Flush while a result is on offer
    ex_ready = 1'b0;
    send(64'd1, 64'd1, OP_ADD, 5'd10);
    wait_ex();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_done_ex_valid", ex_valid, 0);
    chk("flush_done_id_ready", id_ready, 1);
    ex_ready = 1'b1;
    tick();

    // Reset during WAIT
    send(64'd100, 64'd7, OP_DIVU, 5'd11);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstw_alu_in0", alu_in0, 0);
    chk("rstw_alu_op", alu_op, 0);
    chk("rstw_ex_result", ex_result, 0);
    chk("rstw_ex_rd", ex_rd, 0);
    chk("rstw_ex_valid", ex_valid, 0);
    chk("rstw_alu_en", alu_en, 0);
    chk("rstw_id_ready", id_ready, 1);
    tick();
    send(64'd3, 64'd4, OP_ADD, 5'd12);
    wait_ex();
    chk("rstw_add_result", ex_result, 64'd7);
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exu_issue_ctrl.md
Name: exu_issue_ctrl

Overview:
- Execute-stage sequencer directly upstream of the fused ALU.
- Accepts one decoded op at a time from ID over a valid/ready handshake and holds its operands and alu_op stable on the ALU inputs.
- Pulses the ALU start strobe for multi-cycle ops (div/rem, optionally mul) and waits for completion.
- Registers the 64-bit result and presents it to MEM/WB over a second valid/ready handshake.

Parameters:
MUL_MULTICYCLE, 0, 1 = mul ops (alu_op[4:2]==3'b110) take the multi-cycle path; 0 = they complete in one cycle.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
flush  in  1  discard the held op (branch/trap redirect)
id_valid  in  1  ID offers an op
id_ready  out  1  this block accepts the op this cycle
id_in0  in  64  operand 0
id_in1  in  64  operand 1
id_alu_op  in  7  ALU opcode; bit6 = word op
id_rd  in  5  destination register
id_wen  in  1  register write enable
alu_in0  out  64  to ALU in0
alu_in1  out  64  to ALU in1
alu_op  out  7  to ALU alu_op
alu_en  out  1  one-cycle start strobe for multi-cycle ops
alu_valid  in  1  ALU result valid
alu_ready  in  1  ALU can accept a start
alu_out  in  64  ALU result
ex_valid  out  1  result available to MEM/WB
ex_ready  in  1  MEM/WB accepts
ex_result  out  64  registered result
ex_rd  out  5  registered rd
ex_wen  out  1  registered wen

Behaviour:
- Interface: one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n low at a clk edge):
  - state = IDLE.
  - All held registers = 0, so alu_in0/alu_in1/alu_op read 0.
  - ex_result = 0, ex_rd = 0, ex_wen = 0, ex_valid = 0, alu_en = 0.
  - id_ready = 1 after reset.
- Multi-cycle op (MC): alu_op[4:2]==3'b111, or (MUL_MULTICYCLE==1 and alu_op[4:2]==3'b110).
- Held registers:
  - op_in0, op_in1, op_alu, op_rd, op_wen are loaded on id_valid & id_ready.
  - alu_in0/alu_in1/alu_op are driven from these registers in every state, never directly from the id_* inputs.
- States:
  - IDLE:
    - id_ready = 1.
    - On accept -> EXEC.
  - EXEC, non-MC:
    - Capture alu_out into ex_result, and op_rd/op_wen into ex_rd/ex_wen.
    - -> DONE.
    - alu_valid is ignored here.
  - EXEC, MC:
    - alu_en = alu_ready.
    - If alu_ready -> WAIT; otherwise stay in EXEC.
  - WAIT:
    - alu_en = 0.
    - On alu_valid: capture alu_out into ex_result, with ex_rd/ex_wen -> DONE.
  - DONE:
    - ex_valid = 1.
    - ex_result/ex_rd/ex_wen are stable while ex_ready = 0.
    - id_ready = ex_ready.
    - On ex_ready & id_valid: load the new op -> EXEC.
    - On ex_ready & !id_valid -> IDLE.
  - DRAIN:
    - id_ready = 0, ex_valid = 0.
    - On alu_valid: discard the result -> IDLE.
- id_ready = (state==IDLE) | (state==DONE & ex_ready).
- alu_en is asserted only in EXEC, and never on two consecutive cycles.
- Latency, from the accept edge:
  - Non-MC: ex_valid is high 2 cycles after accept.
  - MC: ex_valid rises 1 cycle after alu_valid is seen.
- Throughput: back-to-back non-MC ops with ex_ready held at 1 give one result every 2 cycles.
- flush (synchronous; has priority over all other transitions except reset):
  - In IDLE, EXEC, or DONE -> IDLE, ex_valid drops next cycle, and the op is lost.
  - In EXEC on the same cycle alu_en fires -> DRAIN, because the divider has started and its flush is tied off.
  - In WAIT -> DRAIN.
  - In DRAIN -> stay in DRAIN.
  - id_ready = 0 on any cycle where flush = 1.
- Simultaneous events:
  - flush and alu_valid in WAIT -> IDLE, result discarded.
  - Reset overrides flush and all handshakes.
- Width: results are passed through unmodified; word-op sign extension is done by the ALU. ex_result is 64 bits.

Test Plan:
- Reset then ADD: id_alu_op=7'b0000000, in0=5, in1=7, ex_ready=1 -> ex_valid high 2 cycles after accept, ex_result=12, alu_en never asserted.
- DIVU: alu_op=7'b0011101, in0=100, in1=7, model ALU with alu_valid 10 cycles after alu_en -> alu_en is a single-cycle pulse, alu_op/in held stable throughout, ex_result=14 one cycle after alu_valid. Repeat with REMU (7'b0011111) -> ex_result=2.
- Backpressure: hold ex_ready=0 for 5 cycles while in DONE with ex_result=12 -> ex_result/ex_rd unchanged, id_ready=0; release -> next queued op accepted on the same cycle.
- MC issue stall: alu_ready=0 for 3 cycles in EXEC -> alu_en stays 0, then pulses once when alu_ready=1.
- Flush in WAIT: flush one cycle mid-divide -> DRAIN, id_ready=0 until alu_valid, no ex_valid produced, then IDLE with id_ready=1.
- Reset mid-WAIT: rst_n low one cycle -> next cycle all outputs 0, state IDLE, id_ready=1; a later ADD 3+4 returns 7.
